// File: rtl/tv_pixel_fetch_pkg.sv
// tv_pixel_fetch shared geometry, types and FSM encoding.
// Imported by the interface, the video RAM and the top level.
package tv_pixel_fetch_pkg;

  localparam int H_PIX    = 512;
  localparam int V_LINES  = 287;
  localparam int WORD_W   = 8;
  localparam int ADDR_W   = 15;
  localparam int X_W      = 10;
  localparam int YP_W     = 9;
  localparam int WPL      = H_PIX / WORD_W;
  localparam int LO_W     = $clog2(WORD_W);
  localparam int WX_W     = $clog2(WPL);
  localparam int Y_W      = ADDR_W - WX_W;
  localparam int FB_WORDS = WPL * V_LINES;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } fsm_e;

  // Word address is a concat of line and word column.
  function automatic addr_t fetch_addr(
    input logic [YP_W-1:0] y,
    input logic [X_W-1:0]  x
  );
    return {y[Y_W-1:0], x[LO_W+WX_W-1:LO_W]};
  endfunction

endpackage

// File: rtl/tv_pixel_fetch_if.sv
// Timing strobes from the sync generator plus the host write port.
// The master drives everything; the pixel fetch block is the slave.
interface tv_pixel_fetch_if;
  import tv_pixel_fetch_pkg::*;

  logic            pix_en;
  logic            active;
  logic [X_W-1:0]  x_pos;
  logic [YP_W-1:0] y_pos;
  logic            wr_en;
  addr_t           wr_addr;
  word_t           wr_data;

  modport master (
    output pix_en, active, x_pos, y_pos,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input pix_en, active, x_pos, y_pos,
    input wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/tv_pixel_fetch_vram.sv
// Simple dual-port framebuffer RAM, registered read port.
// Read-before-write on an address collision.
module tv_pixel_fetch_vram
  import tv_pixel_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  we_i,
  input  addr_t wa_i,
  input  word_t wd_i,
  input  logic  re_i,
  input  addr_t ra_i,
  output word_t rd_o
);

  word_t mem_q [FB_WORDS];
  word_t rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/tv_pixel_fetch.sv
// Framebuffer front end: clear FSM, write mux and
// fetch/serialise registers producing a 1-bpp pixel stream.
module tv_pixel_fetch
  import tv_pixel_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  tv_pixel_fetch_if.slave   bus,
  output logic              pix_out,
  output logic              clr_busy
);

  fsm_e            state_q, state_d;
  addr_t           clr_addr_q, clr_addr_d;
  logic [LO_W-1:0] x_lo_q;
  logic            act_q;
  logic            pix_q;

  logic            in_rng;
  logic            rd_en;
  logic            ram_we;
  addr_t           ram_wa;
  word_t           ram_wd;
  word_t           ram_q;

  assign in_rng = (bus.x_pos < X_W'(H_PIX)) &&
                  (bus.y_pos < YP_W'(V_LINES));

  assign rd_en = bus.pix_en & bus.active & in_rng &
                 (bus.x_pos[LO_W-1:0] == '0);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = bus.wr_en;
    ram_wa     = bus.wr_addr;
    ram_wd     = bus.wr_data;
    unique case (state_q)
      ST_CLEAR: begin
        ram_we     = 1'b1;
        ram_wa     = clr_addr_q;
        ram_wd     = '0;
        clr_addr_d = clr_addr_q + addr_t'(1);
        if (clr_addr_q == addr_t'(FB_WORDS - 1)) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      x_lo_q     <= '0;
      act_q      <= 1'b0;
      pix_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      if (bus.pix_en) begin
        x_lo_q <= bus.x_pos[LO_W-1:0];
        act_q  <= bus.active & in_rng;
        // ram_q still holds the previous group here
        pix_q  <= act_q & ~clr_busy &
                  ram_q[LO_W'(WORD_W - 1) - x_lo_q];
      end
    end
  end

  tv_pixel_fetch_vram u_vram (
    .clk  (clk),
    .we_i (ram_we),
    .wa_i (ram_wa),
    .wd_i (ram_wd),
    .re_i (rd_en),
    .ra_i (fetch_addr(bus.y_pos, bus.x_pos)),
    .rd_o (ram_q)
  );

  assign clr_busy = (state_q == ST_CLEAR);
  assign pix_out  = pix_q;

endmodule

// File: tb/tb_tv_pixel_fetch.sv
// Self-checking bench for tv_pixel_fetch against a
// framebuffer-array reference model.
module tb_tv_pixel_fetch;
  import tv_pixel_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_out;
  logic clr_busy;

  tv_pixel_fetch_if bus ();

  tv_pixel_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pix_out  (pix_out),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] fb [FB_WORDS];
  logic out_at [0:513];
  int   const_err;

  function automatic logic model_pix(int x, int y);
    logic [7:0] w;
    if (x < 0 || x >= H_PIX || y < 0 || y >= V_LINES) return 1'b0;
    w = fb[y * (H_PIX / WORD_W) + x / WORD_W];
    return w[WORD_W - 1 - x % WORD_W];
  endfunction

  task automatic idle_inputs();
    bus.pix_en  = 1'b0;
    bus.active  = 1'b0;
    bus.x_pos   = '0;
    bus.y_pos   = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < FB_WORDS; i++) fb[i] = 8'h00;
  endtask

  task automatic host_write(int addr, logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr_t'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    fb[addr] = data;
  endtask

  // Strobes x=0..513 on line y; out_at[x] is pix_out after the
  // strobe presenting x, i.e. pixel x-1.
  task automatic scan_line(int y, int cx, int caddr, logic [7:0] cdata);
    int gap;
    const_err = 0;
    for (int x = 0; x <= 513; x++) begin
      bus.pix_en = 1'b1;
      bus.x_pos  = X_W'(x);
      bus.y_pos  = YP_W'(y);
      bus.active = (x <= 512);
      if (x == cx) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr_t'(caddr);
        bus.wr_data = cdata;
      end
      @(negedge clk);
      bus.pix_en = 1'b0;
      bus.wr_en  = 1'b0;
      out_at[x]  = pix_out;
      gap = $urandom_range(1, 2);
      repeat (gap) begin
        @(negedge clk);
        if (pix_out !== out_at[x]) const_err++;
      end
    end
    bus.active = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic count_clear(input bit inject, output int cnt);
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 20000) begin
      cnt++;
      bus.wr_en   = inject && cnt == 100;
      bus.wr_addr = addr_t'(5);
      bus.wr_data = 8'h3C;
      bus.pix_en  = inject && cnt >= 200 && cnt < 260 && cnt % 2 == 0;
      bus.active  = cnt < 250;
      bus.x_pos   = X_W'(cnt >= 200 ? cnt - 200 : 0);
      bus.y_pos   = '0;
      @(negedge clk);
      if (inject && cnt >= 200 && cnt < 262) begin
        n_tests++;
        if (pix_out !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_pix cnt=%0d got %b exp 0", cnt, pix_out);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    int cnt;
    pulse_reset();
    n_tests++;
    if (pix_out !== 1'b0 || clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state got pix=%b busy=%b exp pix=0 busy=1",
               pix_out, clr_busy);
    end
    count_clear(1'b1, cnt);
    model_clear();
    n_tests++;
    if (cnt != FB_WORDS) begin
      n_fail++;
      $display("FAIL clear_len got %0d exp %0d", cnt, FB_WORDS);
    end
  endtask

  task automatic test_clear_frame();
    int lines [5];
    lines[0] = 0;
    lines[1] = 286;
    lines[2] = 143;
    lines[3] = $urandom_range(1, 285);
    lines[4] = $urandom_range(1, 285);
    foreach (lines[i]) begin
      scan_line(lines[i], -1, 0, 8'h00);
      for (int x = 0; x <= 513; x++) begin
        n_tests++;
        if (out_at[x] !== model_pix(x - 1, lines[i])) begin
          n_fail++;
          $display("FAIL clear_frame y=%0d px=%0d got %b exp %b",
                   lines[i], x - 1, out_at[x], model_pix(x - 1, lines[i]));
        end
      end
      n_tests++;
      if (const_err != 0) begin
        n_fail++;
        $display("FAIL clear_hold got %0d exp 0", const_err);
      end
    end
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    pat = 8'hA5;
    host_write(0, pat);
    scan_line(0, -1, 0, 8'h00);
    for (int x = 0; x <= 513; x++) begin
      n_tests++;
      if (out_at[x] !== model_pix(x - 1, 0)) begin
        n_fail++;
        $display("FAIL pattern px=%0d got %b exp %b",
                 x - 1, out_at[x], model_pix(x - 1, 0));
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (out_at[i + 1] !== pat[7 - i]) begin
        n_fail++;
        $display("FAIL a5_bit px=%0d got %b exp %b", i, out_at[i + 1], pat[7 - i]);
      end
    end
    n_tests++;
    if (out_at[9] !== 1'b0 || out_at[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_edges got p8=%b pre=%b exp 0 0", out_at[9], out_at[0]);
    end
  endtask

  task automatic test_corner();
    host_write(286 * 64 + 63, 8'h01);
    scan_line(286, -1, 0, 8'h00);
    for (int x = 0; x <= 513; x++) begin
      n_tests++;
      if (out_at[x] !== model_pix(x - 1, 286)) begin
        n_fail++;
        $display("FAIL corner px=%0d got %b exp %b",
                 x - 1, out_at[x], model_pix(x - 1, 286));
      end
    end
    n_tests++;
    if (out_at[512] !== 1'b1 || out_at[511] !== 1'b0 || out_at[513] !== 1'b0) begin
      n_fail++;
      $display("FAIL corner_px got p510=%b p511=%b p512=%b exp 0 1 0",
               out_at[511], out_at[512], out_at[513]);
    end
  endtask

  task automatic test_idle_write();
    host_write(5, 8'h3C);
    scan_line(0, -1, 0, 8'h00);
    for (int x = 0; x <= 513; x++) begin
      n_tests++;
      if (out_at[x] !== model_pix(x - 1, 0)) begin
        n_fail++;
        $display("FAIL idle_write px=%0d got %b exp %b",
                 x - 1, out_at[x], model_pix(x - 1, 0));
      end
    end
    n_tests++;
    if (out_at[43] !== 1'b1 || out_at[41] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_px got p42=%b p40=%b exp 1 0", out_at[43], out_at[41]);
    end
  endtask

  task automatic test_collision();
    scan_line(0, 16, 2, 8'hFF);
    for (int x = 0; x <= 513; x++) begin
      n_tests++;
      if (out_at[x] !== model_pix(x - 1, 0)) begin
        n_fail++;
        $display("FAIL coll_old px=%0d got %b exp %b",
                 x - 1, out_at[x], model_pix(x - 1, 0));
      end
    end
    fb[2] = 8'hFF;
    scan_line(0, -1, 0, 8'h00);
    for (int x = 0; x <= 513; x++) begin
      n_tests++;
      if (out_at[x] !== model_pix(x - 1, 0)) begin
        n_fail++;
        $display("FAIL coll_new px=%0d got %b exp %b",
                 x - 1, out_at[x], model_pix(x - 1, 0));
      end
    end
    n_tests++;
    if (out_at[17] !== 1'b1 || out_at[24] !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_px got p16=%b p23=%b exp 1 1", out_at[17], out_at[24]);
    end
  endtask

  task automatic test_random();
    int y;
    for (int r = 0; r < 4; r++) begin
      y = $urandom_range(0, V_LINES - 1);
      for (int k = 0; k < 10; k++)
        host_write(y * 64 + $urandom_range(0, 63), 8'($urandom));
      host_write($urandom_range(0, FB_WORDS - 1), 8'($urandom));
      scan_line(y, -1, 0, 8'h00);
      for (int x = 0; x <= 513; x++) begin
        n_tests++;
        if (out_at[x] !== model_pix(x - 1, y)) begin
          n_fail++;
          $display("FAIL random y=%0d px=%0d got %b exp %b",
                   y, x - 1, out_at[x], model_pix(x - 1, y));
        end
      end
      n_tests++;
      if (const_err != 0) begin
        n_fail++;
        $display("FAIL random_hold got %0d exp 0", const_err);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    int lines [2];
    pulse_reset();
    repeat (9000) @(negedge clk);
    reset      = 1'b1;
    bus.pix_en = 1'b1;
    bus.active = 1'b1;
    bus.x_pos  = X_W'(100);
    bus.y_pos  = YP_W'(10);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    n_tests++;
    if (pix_out !== 1'b0 || clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got pix=%b busy=%b exp pix=0 busy=1",
               pix_out, clr_busy);
    end
    count_clear(1'b0, cnt);
    model_clear();
    n_tests++;
    if (cnt != FB_WORDS) begin
      n_fail++;
      $display("FAIL mid_clear_len got %0d exp %0d", cnt, FB_WORDS);
    end
    lines[0] = 0;
    lines[1] = 286;
    foreach (lines[i]) begin
      scan_line(lines[i], -1, 0, 8'h00);
      for (int x = 0; x <= 513; x++) begin
        n_tests++;
        if (out_at[x] !== model_pix(x - 1, lines[i])) begin
          n_fail++;
          $display("FAIL recleared y=%0d px=%0d got %b exp %b",
                   lines[i], x - 1, out_at[x], model_pix(x - 1, lines[i]));
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_clear_frame();
    test_pattern();
    test_corner();
    test_idle_write();
    test_collision();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
